// File: rtl/dnnweaver_arb_pkg.sv
// Shared definitions for the delay-pipe arbiter: a constant-evaluable
// ceiling-log2 helper and the ID/credit widths for the default build.
package dnnweaver_arb_pkg;

  // Ceiling log2 usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      rem    = rem >> 1;
      result = result + 1;
    end
    return result;
  endfunction

  localparam int NUM_REQ_DEF      = 4;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int PIPE_LATENCY_DEF = 3;
  localparam int MAX_CREDITS_DEF  = 8;

  localparam int ID_W  = clog2(NUM_REQ_DEF);
  localparam int CRD_W = clog2(MAX_CREDITS_DEF + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// found searching upward (with wrap) from PTR. EN=0 suppresses any grant.
module rr_arbiter
  import dnnweaver_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [clog2(NUM_REQ)-1:0] PTR,
  input  logic                      EN,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [clog2(NUM_REQ)-1:0] GNT_ID
);

  localparam int IDB = clog2(NUM_REQ);

  // Rotating priority search starting at PTR.
  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    GNT    = '0;
    GNT_ID = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // NOTE: blocking assignments here because later iterations must see
      // the updated found flag within the same evaluation.
      idx = (int'(PTR) + off) % NUM_REQ;
      if (EN && !found && REQ[idx]) begin
        GNT[idx] = 1'b1;
        GNT_ID   = IDB'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_pipe_arbiter.sv
// Shares one external fixed-latency delay line among NUM_REQ requesters.
// A round-robin winner's payload is registered into the delay line while a
// parallel tag/valid shadow pipe tracks which requester owns each slot, so
// results leave tagged. Issue is gated by downstream credits because the
// delay line cannot stall.
module delay_pipe_arbiter
  import dnnweaver_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
  parameter int MAX_CREDITS  = MAX_CREDITS_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [DATA_WIDTH-1:0]         PIPE_IN_DATA,
  input  logic [DATA_WIDTH-1:0]         PIPE_OUT_DATA,
  output logic                          RSP_VALID,
  output logic [clog2(NUM_REQ)-1:0]     RSP_ID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  input  logic                          CREDIT_RETURN,
  output logic                          CREDIT_ERR,
  output logic                          IDLE
);

  localparam int             IDB      = clog2(NUM_REQ);
  localparam int             CRB      = clog2(MAX_CREDITS + 1);
  localparam logic [CRB-1:0] CRD_FULL = CRB'(MAX_CREDITS);

  logic [CRB-1:0]        credits;
  logic [IDB-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDB-1:0]        gnt_id;
  logic                  issue;
  logic [PIPE_LATENCY:0] shadow_vld;
  logic [IDB-1:0]        shadow_id [PIPE_LATENCY+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .REQ    (REQ_VALID),
    .PTR    (rr_ptr),
    .EN     (credits != '0),
    .GNT    (gnt),
    .GNT_ID (gnt_id)
  );

  assign REQ_READY = gnt;
  assign issue     = |(REQ_VALID & gnt);
  assign IDLE      = (shadow_vld == '0) && (credits == CRD_FULL);

  // Round-robin pointer moves just past the most recent winner.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gnt_id == IDB'(NUM_REQ - 1)) ? '0 : gnt_id + IDB'(1);
    end
  end

  // Credit counter; a return into a full counter saturates and flags an error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      credits    <= CRD_FULL;
      CREDIT_ERR <= 1'b0;
    end else begin
      case ({issue, CREDIT_RETURN})
        2'b10: credits <= credits - CRB'(1);
        2'b01: begin
          if (credits == CRD_FULL) CREDIT_ERR <= 1'b1;
          else                     credits    <= credits + CRB'(1);
        end
        default: ;
      endcase
    end
  end

  // Delay-line input register: holds the last issued payload between issues.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PIPE_IN_DATA <= '0;
    end else if (issue) begin
      PIPE_IN_DATA <= REQ_DATA[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Shadow valid bits, aligned stage-for-stage with the external delay line.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_vld <= '0;
    end else begin
      for (int i = PIPE_LATENCY; i >= 1; i--) shadow_vld[i] <= shadow_vld[i-1];
      shadow_vld[0] <= issue;
    end
  end

  // Shadow requester tags travelling beside the valid bits.
  // NOTE: the tag array is not reset; a tag is only consumed when its valid
  // bit is set, and the valid bits are reset, so stale tags are harmless.
  always_ff @(posedge CLK) begin
    for (int i = PIPE_LATENCY; i >= 1; i--) shadow_id[i] <= shadow_id[i-1];
    shadow_id[0] <= gnt_id;
  end

  // Response registers: capture the delay-line output when its slot is valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_DATA  <= '0;
    end else begin
      RSP_VALID <= shadow_vld[PIPE_LATENCY];
      if (shadow_vld[PIPE_LATENCY]) begin
        RSP_ID   <= shadow_id[PIPE_LATENCY];
        RSP_DATA <= PIPE_OUT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Directed bench for delay_pipe_arbiter: a 3-stage register delay line
// around the default build, plus a second PIPE_LATENCY=0 build whose delay
// line is a plain wire.
module tb_delay_pipe_arbiter;
  import dnnweaver_arb_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int MC  = 8;

  logic CLK;
  logic RESET;

  // Default build (PIPE_LATENCY=3)
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    pipe_in;
  logic [DW-1:0]    pipe_out;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             credit_return;
  logic             credit_err;
  logic             idle;
  logic [DW-1:0]    dl [LAT];

  // Zero-latency build
  logic [NR-1:0]    req_valid_z;
  logic [NR*DW-1:0] req_data_z;
  logic [NR-1:0]    req_ready_z;
  logic [DW-1:0]    pipe_in_z;
  logic             rsp_valid_z;
  logic [ID_W-1:0]  rsp_id_z;
  logic [DW-1:0]    rsp_data_z;
  logic             credit_err_z;
  logic             idle_z;

  int n_tests;
  int n_fail;
  int grants;
  int rsp_seen;

  delay_pipe_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LATENCY(LAT), .MAX_CREDITS(MC)
  ) u_dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ_VALID     (req_valid),
    .REQ_DATA      (req_data),
    .REQ_READY     (req_ready),
    .PIPE_IN_DATA  (pipe_in),
    .PIPE_OUT_DATA (pipe_out),
    .RSP_VALID     (rsp_valid),
    .RSP_ID        (rsp_id),
    .RSP_DATA      (rsp_data),
    .CREDIT_RETURN (credit_return),
    .CREDIT_ERR    (credit_err),
    .IDLE          (idle)
  );

  delay_pipe_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LATENCY(0), .MAX_CREDITS(MC)
  ) u_dut_z (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ_VALID     (req_valid_z),
    .REQ_DATA      (req_data_z),
    .REQ_READY     (req_ready_z),
    .PIPE_IN_DATA  (pipe_in_z),
    .PIPE_OUT_DATA (pipe_in_z),
    .RSP_VALID     (rsp_valid_z),
    .RSP_ID        (rsp_id_z),
    .RSP_DATA      (rsp_data_z),
    .CREDIT_RETURN (1'b0),
    .CREDIT_ERR    (credit_err_z),
    .IDLE          (idle_z)
  );

  // External register delay line with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= pipe_in;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end
  assign pipe_out = dl[LAT-1];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land just after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic exp_v;
    n_tests       = 0;
    n_fail        = 0;
    RESET         = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    credit_return = 1'b0;
    req_valid_z   = '0;
    req_data_z    = '0;
    tick();
    tick();
    RESET = 1'b0;
    #1;

    // Reset state
    check("rst_ready",    32'(req_ready),  32'h0);
    check("rst_pipe_in",  32'(pipe_in),    32'h0);
    check("rst_rsp_v",    32'(rsp_valid),  32'h0);
    check("rst_rsp_id",   32'(rsp_id),     32'h0);
    check("rst_rsp_data", 32'(rsp_data),   32'h0);
    check("rst_err",      32'(credit_err), 32'h0);
    check("rst_idle",     32'(idle),       32'h1);

    // Round-robin: all request, credits returned every issuing cycle
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'hA000 + 16'(i);
    for (int k = 0; k < 14; k++) begin
      exp_v = (k >= 5 && k < 13);
      check("rr_rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        check("rr_rsp_id",   32'(rsp_id),   32'((k - 5) % 4));
        check("rr_rsp_data", 32'(rsp_data), 32'h0000A000 + 32'((k - 5) % 4));
      end
      req_valid     = (k < 8) ? 4'b1111 : 4'b0000;
      credit_return = (k < 8);
      #1;
      if (k < 8) check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    credit_return = 1'b0;
    #1;
    check("rr_idle_after",    32'(idle),    32'h1);
    check("rr_pipe_in_holds", 32'(pipe_in), 32'hA003);

    // Single op from requester 1
    req_data[1*DW +: DW] = 16'h1234;
    req_valid = 4'b0010;
    #1;
    check("single_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin
        check("single_pipe_in", 32'(pipe_in), 32'h1234);
        check("single_busy",    32'(idle),    32'h0);
      end
      check("single_rsp_valid", 32'(rsp_valid), 32'(k == 5));
      if (k == 5) begin
        check("single_rsp_id",   32'(rsp_id),   32'h1);
        check("single_rsp_data", 32'(rsp_data), 32'h1234);
      end
      tick();
    end
    check("single_idle_credit", 32'(idle), 32'h0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    #1;
    check("single_idle_back", 32'(idle), 32'h1);

    // Credit exhaustion with requester 0 held
    req_data[0*DW +: DW] = 16'h0BEE;
    req_valid = 4'b0001;
    grants = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req_ready[0]) grants++;
      tick();
    end
    check("exh_grant_count", 32'(grants), 32'd8);
    #1;
    check("exh_ready_zero", 32'(req_ready), 32'h0);
    credit_return = 1'b1;
    #1;
    check("exh_ready_during_return", 32'(req_ready), 32'h0);
    tick();
    credit_return = 1'b0;
    #1;
    check("exh_one_more", 32'(req_ready), 32'h1);
    tick();
    #1;
    check("exh_again_zero", 32'(req_ready), 32'h0);

    // Simultaneous issue and return at credits=1
    credit_return = 1'b1;
    tick();
    #1;
    check("simul_grant", 32'(req_ready), 32'h1);
    tick();
    credit_return = 1'b0;
    #1;
    check("simul_still_grant", 32'(req_ready), 32'h1);
    tick();
    #1;
    check("simul_drained", 32'(req_ready), 32'h0);
    req_valid = '0;
    credit_return = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    credit_return = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("refill_idle", 32'(idle),       32'h1);
    check("refill_err",  32'(credit_err), 32'h0);

    // Spurious return into a full counter
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    #1;
    check("err_set", 32'(credit_err), 32'h1);
    for (int k = 0; k < 3; k++) tick();
    check("err_sticky",    32'(credit_err), 32'h1);
    check("err_idle_full", 32'(idle),       32'h1);

    // Reset mid-flight: three ops issued, reset two cycles after the last
    rsp_seen = 0;
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) tick();
    req_valid = '0;
    tick();
    if (rsp_valid) rsp_seen++;
    RESET = 1'b1;
    #1;
    if (rsp_valid) rsp_seen++;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    check("rst_mid_idle", 32'(idle),       32'h1);
    check("rst_mid_err",  32'(credit_err), 32'h0);
    req_valid = 4'b1111;
    #1;
    check("rst_mid_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) rsp_seen++;
    end
    check("rst_mid_no_rsp", 32'(rsp_seen), 32'h0);

    // Zero-latency build: request at cycle 5, response at cycle 7
    check("z_rsp_idle", 32'(rsp_valid_z), 32'h0);
    for (int k = 0; k < 5; k++) tick();
    req_data_z[2*DW +: DW] = 16'h5A5A;
    req_valid_z = 4'b0100;
    #1;
    check("z_grant", 32'(req_ready_z), 32'h4);
    tick();
    req_valid_z = '0;
    check("z_rsp_c6",   32'(rsp_valid_z), 32'h0);
    check("z_pipe_in",  32'(pipe_in_z),   32'h5A5A);
    tick();
    check("z_rsp_c7",   32'(rsp_valid_z), 32'h1);
    check("z_rsp_id",   32'(rsp_id_z),    32'h2);
    check("z_rsp_data", 32'(rsp_data_z),  32'h5A5A);
    tick();
    check("z_rsp_c8",   32'(rsp_valid_z), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
